vliw_regfile: RTL and testbench
===============================

# vliw_regfile

Four-lane integer register file for the VLIW integer execution cluster. It is the responder side of each lane's widened register-file port: it serves each lane's two read addresses and its single write request. It resolves same-cycle write collisions in bundle order and bypasses same-cycle write data to readers. It sits beside the four IEU lanes, one level above them, and replaces the per-lane private register file.

## Interface
- P — cvw_t configuration. Uses P.XLEN and P.E_SUPPORTED; E_SUPPORTED gives 16 architectural registers instead of 32.
- clk  input  1  core clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; clears all registers, flags and counters
- a1  input  [3:0][4:0]  read-port-1 address, per lane (lane 0 = oldest in bundle)
- a2  input  [3:0][4:0]  read-port-2 address, per lane
- rd1  output  [3:0][XLEN-1:0]  read data for a1, per lane
- rd2  output  [3:0][XLEN-1:0]  read data for a2, per lane
- we3  input  [3:0]  write enable, per lane
- a3  input  [3:0][4:0]  write address, per lane
- wd3  input  [3:0][XLEN-1:0]  write data, per lane
- DbgAdr  input  5  debug/bench read address
- DbgData  output  XLEN  combinational read of stored state, no bypass
- WriteConflictW  output  1  registered; high one cycle after any cycle with colliding writes
- ConflictCount  output  16  saturating count of collision cycles since reset

## Operation
- Storage: x1..x31, or x1..x15 when E_SUPPORTED. x0 is not stored.
- Effective write: lane i writes when we3[i]=1 and a3[i]≠0. In E mode, a3[i][4] must also be 0.
- Priority: on a same-cycle address collision, the highest-numbered lane wins, matching bundle program order. Lower lanes writing the same register are dropped.
- Commit: winning data is written into storage on the rising edge of clk.
- Read, combinational, per port p of lane l:
  - address 0 → 0
  - E mode with address bit 4 set → 0
  - address matches any effective write this cycle → wd3 of the winning (highest) lane
  - otherwise → stored value
- The same-cycle bypass makes the register file write-before-read, equivalent to a negedge write.
- DbgData reads storage only, with no bypass, and returns 0 for x0 or out-of-range addresses.
- Collision: exists when two or more lanes make effective writes to the same register in a cycle.
  - WriteConflictW <= collision, one cycle later.
  - ConflictCount increments by 1 per collision cycle and saturates at 16'hFFFF.
  - A collision is legal behaviour; it is reported only for performance counters and assertions.

## Timing
- Read latency: 0 cycles (combinational from a1/a2/a3/we3/wd3).
- Write latency: 1 edge. Storage and DbgData reflect a write after the next rising edge.
- Reset asserted (reset=0), immediately and asynchronously:
  - all registers become 0
  - WriteConflictW=0, ConflictCount=0
  - rd1/rd2 return 0 unless bypassing
- Reset release is synchronized by the top level. Writes are accepted from the first rising edge with reset=1.
- Reset asserted mid-write: the write is lost and the register is 0.
- Counter at 16'hFFFF plus another collision: the count stays 16'hFFFF.
- A lane writing x0 never counts toward a collision and never bypasses.

## Structure
- The shared cvw package gains:
  - localparam NLANES = 4
  - a typedef for the lane-indexed address array, logic [NLANES-1:0][4:0]
- One sub-module, vliw_wrarb, implements the per-address write arbiter. It takes we3/a3/wd3, applies priority, and produces:
  - winning-lane one-hot per register
  - winning data
  - the collision flag
- The arbiter is reused by both the commit path and the bypass path.
- Storage is a flat array of XLEN-wide flops with async clear. No SRAM macro is used, because reset must clear all registers.

## Test plan
- Reset then read: reset=0 then 1 → every rd1/rd2/DbgData = 0 for addresses 0..31.
- Single write/read-back:
  - Cycle 0: lane 2 writes x5 = 0xDEADBEEF; same cycle, lane 0 reads a1 = 5 → rd1[0] = 0xDEADBEEF (bypass).
  - Next cycle, with no write: DbgAdr = 5 → 0xDEADBEEF.
- Collision priority:
  - Lanes 0, 1 and 3 all write x7 with values 1, 2 and 3 → next cycle x7 = 3, WriteConflictW = 1, ConflictCount = 1.
  - Following cycle, with no collision: WriteConflictW = 0.
- x0 and E-mode:
  - A write to x0 with 0x1234 → rd = 0 and no conflict counted.
  - E config, write x20 → ignored; reads of x20 return 0.
- Counter saturation: force 65,536 collision cycles → ConflictCount holds 0xFFFF.
- Async reset mid-operation: assert reset between edges while writes are pending → x5 and x7 = 0 immediately, ConflictCount = 0, and no write commits on the next edge.

Source files
------------

// File: rtl/vliw_regfile_pkg.sv
// Shared configuration and lane-array types for the VLIW integer register file.
package vliw_regfile_pkg;

    // Core configuration subset consumed by the register file
    typedef struct packed {
        int unsigned XLEN;
        logic        E_SUPPORTED;
    } cvw_t;

    localparam cvw_t CVW_RV32I = '{XLEN: 32, E_SUPPORTED: 1'b0};

    localparam int unsigned NLANES = 4;
    localparam int unsigned NARCH  = 32;

    // Lane-indexed 5-bit register address array (lane 0 = oldest in bundle)
    typedef logic [NLANES-1:0][4:0] lane_addr_t;

    // Number of architectural registers, including x0
    function automatic int unsigned num_regs(input logic e_supported);
        return e_supported ? 16 : 32;
    endfunction

endpackage

// File: rtl/vliw_regfile_wrarb.sv
// Per-address write arbiter: qualifies each lane's write, picks the
// highest-numbered lane per register and flags same-register collisions.
module vliw_wrarb
    import vliw_regfile_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic        E_SUPPORTED = 1'b0
) (
    input  logic [NLANES-1:0]              i_we,
    input  lane_addr_t                     i_addr,
    input  logic [NLANES-1:0][XLEN-1:0]    i_wdata,
    output logic [NARCH-1:0][NLANES-1:0]   o_win_onehot,
    output logic [NARCH-1:0][XLEN-1:0]     o_win_data,
    output logic                           o_collision
);

    logic [NLANES-1:0] w_eff;

    // A lane writes only for a non-zero, in-range destination
    always_comb begin
        w_eff = '0;
        for (int unsigned l = 0; l < NLANES; l++) begin
            w_eff[l] = i_we[l] && (i_addr[l] != 5'd0) && !(E_SUPPORTED && i_addr[l][4]);
        end
    end

    // Per-register select; ascending lane scan lets the youngest lane overwrite
    always_comb begin
        o_win_onehot = '0;
        o_win_data   = '0;
        for (int unsigned r = 1; r < NARCH; r++) begin
            for (int unsigned l = 0; l < NLANES; l++) begin
                if (w_eff[l] && (i_addr[l] == 5'(r))) begin
                    o_win_onehot[r]    = '0;
                    o_win_onehot[r][l] = 1'b1;
                    o_win_data[r]      = i_wdata[l];
                end
            end
        end
    end

    // Collision when any two effective writes target the same register
    always_comb begin
        o_collision = 1'b0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            for (int unsigned j = i + 1; j < NLANES; j++) begin
                if (w_eff[i] && w_eff[j] && (i_addr[i] == i_addr[j])) begin
                    o_collision = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vliw_regfile.sv
// Four-lane integer register file: 2 reads + 1 write per lane, bundle-order
// write priority, same-cycle write-to-read bypass, collision reporting.
module vliw_regfile
    import vliw_regfile_pkg::*;
#(
    parameter cvw_t P = CVW_RV32I
) (
    input  logic                          clk,
    input  logic                          reset,
    input  lane_addr_t                    a1,
    input  lane_addr_t                    a2,
    output logic [NLANES-1:0][P.XLEN-1:0] rd1,
    output logic [NLANES-1:0][P.XLEN-1:0] rd2,
    input  logic [NLANES-1:0]             we3,
    input  lane_addr_t                    a3,
    input  logic [NLANES-1:0][P.XLEN-1:0] wd3,
    input  logic [4:0]                    DbgAdr,
    output logic [P.XLEN-1:0]             DbgData,
    output logic                          WriteConflictW,
    output logic [15:0]                   ConflictCount
);

    localparam int unsigned XLEN  = P.XLEN;
    localparam int unsigned NREGS = num_regs(P.E_SUPPORTED);

    logic [NARCH-1:0][NLANES-1:0] w_win_onehot;
    logic [NARCH-1:0][XLEN-1:0]   w_win_data;
    logic                         w_collision;
    logic [NARCH-1:0]             w_wr_valid;
    logic [NARCH-1:0][XLEN-1:0]   w_regs;

    logic                         r_conflict;
    logic [15:0]                  r_count;

    // Single arbiter feeds both the commit path and the read bypass
    vliw_wrarb #(
        .XLEN        (XLEN),
        .E_SUPPORTED (P.E_SUPPORTED)
    ) u_wrarb (
        .i_we         (we3),
        .i_addr       (a3),
        .i_wdata      (wd3),
        .o_win_onehot (w_win_onehot),
        .o_win_data   (w_win_data),
        .o_collision  (w_collision)
    );

    // A register is written this cycle when some lane won it
    always_comb begin
        w_wr_valid = '0;
        for (int unsigned r = 0; r < NARCH; r++) begin
            w_wr_valid[r] = |w_win_onehot[r];
        end
    end

    // Flop storage only for x1..x(NREGS-1); x0 and out-of-range read as zero
    for (genvar r = 0; r < NARCH; r++) begin : g_reg
        if ((r != 0) && (r < NREGS)) begin : g_store
            logic [XLEN-1:0] r_q;

            // Commit the arbitrated winner; async clear on reset
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_q <= '0;
                end else if (w_wr_valid[r]) begin
                    r_q <= w_win_data[r];
                end
            end

            assign w_regs[r] = r_q;
        end else begin : g_none
            assign w_regs[r] = '0;
        end
    end

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        if ((a == 5'd0) || (P.E_SUPPORTED && a[4])) begin
            return '0;
        end else if (w_wr_valid[a]) begin
            return w_win_data[a];
        end else begin
            return w_regs[a];
        end
    endfunction

    // Combinational read ports with same-cycle write bypass
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int unsigned l = 0; l < NLANES; l++) begin
            rd1[l] = rf_read(a1[l]);
            rd2[l] = rf_read(a2[l]);
        end
    end

    assign DbgData = w_regs[DbgAdr];

    // Registered collision flag and saturating collision counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conflict <= 1'b0;
            r_count    <= '0;
        end else begin
            r_conflict <= w_collision;
            if (w_collision && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign WriteConflictW = r_conflict;
    assign ConflictCount  = r_count;

endmodule

// File: tb/tb_vliw_regfile.sv
// Self-checking bench for vliw_regfile: directed scenarios plus randomized
// traffic against a program-order reference model, for both I and E configs.
module tb_vliw_regfile;
    import vliw_regfile_pkg::*;

    localparam cvw_t P_I = '{XLEN: 32, E_SUPPORTED: 1'b0};
    localparam cvw_t P_E = '{XLEN: 32, E_SUPPORTED: 1'b1};

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    lane_addr_t       a1, a2, a3;
    logic [3:0]       we3;
    logic [3:0][31:0] wd3;
    logic [4:0]       DbgAdr;

    logic [3:0][31:0] rd1_n, rd2_n, rd1_e, rd2_e;
    logic [31:0]      dbg_n, dbg_e;
    logic             cf_n, cf_e;
    logic [15:0]      cnt_n, cnt_e;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state, index 0 = I config, 1 = E config
    logic [31:0] m_reg [2][32];
    logic        m_cf  [2];
    logic [15:0] m_cnt [2];

    always #20 clk = ~clk;

    vliw_regfile #(.P(P_I)) dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n),
        .we3(we3), .a3(a3), .wd3(wd3), .DbgAdr(DbgAdr), .DbgData(dbg_n),
        .WriteConflictW(cf_n), .ConflictCount(cnt_n)
    );

    vliw_regfile #(.P(P_E)) dut_e (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_e), .rd2(rd2_e),
        .we3(we3), .a3(a3), .wd3(wd3), .DbgAdr(DbgAdr), .DbgData(dbg_e),
        .WriteConflictW(cf_e), .ConflictCount(cnt_e)
    );

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    // ---------------- reference model ----------------
    function automatic bit m_eff(int l, int md);
        return we3[l] && (a3[l] != 5'd0) && !(md == 1 && a3[l][4]);
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a, int md);
        logic [31:0] v;
        if (a == 5'd0 || (md == 1 && a[4])) return 32'h0;
        v = m_reg[md][a];
        for (int l = 0; l < 4; l++)
            if (m_eff(l, md) && a3[l] == a) v = wd3[l];
        return v;
    endfunction

    function automatic bit m_coll(int md);
        int hits [32];
        foreach (hits[k]) hits[k] = 0;
        for (int l = 0; l < 4; l++)
            if (m_eff(l, md)) hits[a3[l]]++;
        foreach (hits[k]) if (hits[k] >= 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_zero();
        for (int md = 0; md < 2; md++) begin
            for (int r = 0; r < 32; r++) m_reg[md][r] = 32'h0;
            m_cf[md] = 1'b0;
            m_cnt[md] = 16'h0;
        end
    endtask

    // Advance one clock edge and update the model with the inputs present at it
    task automatic tick();
        bit c;
        @(posedge clk);
        if (!reset) m_zero();
        else begin
            for (int md = 0; md < 2; md++) begin
                c = m_coll(md);
                for (int l = 0; l < 4; l++)
                    if (m_eff(l, md)) m_reg[md][a3[l]] = wd3[l];
                m_cf[md] = c;
                if (c && m_cnt[md] != 16'hFFFF) m_cnt[md]++;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        we3 = '0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; DbgAdr = '0;
    endtask

    function automatic logic [4:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 5'($urandom_range(0, 31));
            1: return 5'($urandom_range(0, 3));
            2: return 5'($urandom_range(16, 19));
            default: return 5'($urandom_range(4, 7));
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [4:0] a;
        clear_inputs();
        reset = 1'b0;
        m_zero();
        #21;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            a1 = {4{a}}; a2 = {4{a}}; DbgAdr = a;
            #1;
            for (int l = 0; l < 4; l++) begin
                n_cmp += 4;
                if (rd1_n[l] !== 32'h0) begin n_fail++; $display("FAIL reset_rd1_n x%0d lane%0d: got %h expected 0", i, l, rd1_n[l]); end
                if (rd2_n[l] !== 32'h0) begin n_fail++; $display("FAIL reset_rd2_n x%0d lane%0d: got %h expected 0", i, l, rd2_n[l]); end
                if (rd1_e[l] !== 32'h0) begin n_fail++; $display("FAIL reset_rd1_e x%0d lane%0d: got %h expected 0", i, l, rd1_e[l]); end
                if (rd2_e[l] !== 32'h0) begin n_fail++; $display("FAIL reset_rd2_e x%0d lane%0d: got %h expected 0", i, l, rd2_e[l]); end
            end
            n_cmp += 2;
            if (dbg_n !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_n x%0d: got %h expected 0", i, dbg_n); end
            if (dbg_e !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_e x%0d: got %h expected 0", i, dbg_e); end
        end
        n_cmp += 4;
        if (cf_n !== 1'b0)   begin n_fail++; $display("FAIL reset_cf_n: got %b expected 0", cf_n); end
        if (cf_e !== 1'b0)   begin n_fail++; $display("FAIL reset_cf_e: got %b expected 0", cf_e); end
        if (cnt_n !== 16'h0) begin n_fail++; $display("FAIL reset_cnt_n: got %h expected 0", cnt_n); end
        if (cnt_e !== 16'h0) begin n_fail++; $display("FAIL reset_cnt_e: got %h expected 0", cnt_e); end
        clear_inputs();
        tick();
    endtask

    task automatic test_single_write();
        clear_inputs();
        we3[2] = 1'b1; a3[2] = 5'd5; wd3[2] = 32'hDEADBEEF; a1[0] = 5'd5;
        #2;
        n_cmp += 2;
        if (rd1_n[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_bypass_n: got %h expected deadbeef", rd1_n[0]); end
        if (rd1_e[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_bypass_e: got %h expected deadbeef", rd1_e[0]); end
        tick();
        clear_inputs();
        DbgAdr = 5'd5;
        #2;
        n_cmp += 4;
        if (dbg_n !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_dbg_n: got %h expected deadbeef", dbg_n); end
        if (dbg_e !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_dbg_e: got %h expected deadbeef", dbg_e); end
        if (cf_n !== 1'b0) begin n_fail++; $display("FAIL single_cf_n: got %b expected 0", cf_n); end
        if (cnt_n !== 16'h0) begin n_fail++; $display("FAIL single_cnt_n: got %h expected 0", cnt_n); end
        tick();
    endtask

    task automatic test_collision();
        clear_inputs();
        we3 = 4'b1011;
        a3[0] = 5'd7; a3[1] = 5'd7; a3[3] = 5'd7;
        wd3[0] = 32'd1; wd3[1] = 32'd2; wd3[3] = 32'd3;
        a2[1] = 5'd7;
        #2;
        n_cmp += 2;
        if (rd2_n[1] !== 32'd3) begin n_fail++; $display("FAIL coll_bypass_n: got %h expected 3", rd2_n[1]); end
        if (rd2_e[1] !== 32'd3) begin n_fail++; $display("FAIL coll_bypass_e: got %h expected 3", rd2_e[1]); end
        tick();
        clear_inputs();
        DbgAdr = 5'd7;
        #2;
        n_cmp += 6;
        if (dbg_n !== 32'd3)  begin n_fail++; $display("FAIL coll_dbg_n: got %h expected 3", dbg_n); end
        if (dbg_e !== 32'd3)  begin n_fail++; $display("FAIL coll_dbg_e: got %h expected 3", dbg_e); end
        if (cf_n !== 1'b1)    begin n_fail++; $display("FAIL coll_cf_n: got %b expected 1", cf_n); end
        if (cf_e !== 1'b1)    begin n_fail++; $display("FAIL coll_cf_e: got %b expected 1", cf_e); end
        if (cnt_n !== 16'd1)  begin n_fail++; $display("FAIL coll_cnt_n: got %h expected 1", cnt_n); end
        if (cnt_e !== 16'd1)  begin n_fail++; $display("FAIL coll_cnt_e: got %h expected 1", cnt_e); end
        tick();
        n_cmp += 2;
        if (cf_n !== 1'b0)   begin n_fail++; $display("FAIL coll_cf_clear_n: got %b expected 0", cf_n); end
        if (cnt_n !== 16'd1) begin n_fail++; $display("FAIL coll_cnt_hold_n: got %h expected 1", cnt_n); end
    endtask

    task automatic test_x0();
        clear_inputs();
        we3 = 4'b0011;
        wd3[0] = 32'h1234; wd3[1] = 32'h5678;
        #2;
        n_cmp += 2;
        if (rd1_n[0] !== 32'h0) begin n_fail++; $display("FAIL x0_rd_n: got %h expected 0", rd1_n[0]); end
        if (rd2_e[1] !== 32'h0) begin n_fail++; $display("FAIL x0_rd_e: got %h expected 0", rd2_e[1]); end
        tick();
        n_cmp += 4;
        if (cf_n !== 1'b0)   begin n_fail++; $display("FAIL x0_cf_n: got %b expected 0", cf_n); end
        if (cnt_n !== 16'd1) begin n_fail++; $display("FAIL x0_cnt_n: got %h expected 1", cnt_n); end
        if (cnt_e !== 16'd1) begin n_fail++; $display("FAIL x0_cnt_e: got %h expected 1", cnt_e); end
        if (dbg_n !== 32'h0) begin n_fail++; $display("FAIL x0_dbg_n: got %h expected 0", dbg_n); end
        clear_inputs();
        tick();
    endtask

    task automatic test_emode();
        clear_inputs();
        we3 = 4'b0110;
        a3[1] = 5'd20; a3[2] = 5'd20;
        wd3[1] = 32'h0000CAFE; wd3[2] = 32'h0000BEEF;
        a1[3] = 5'd20;
        #2;
        n_cmp += 2;
        if (rd1_n[3] !== 32'h0000BEEF) begin n_fail++; $display("FAIL e_bypass_n: got %h expected 0000beef", rd1_n[3]); end
        if (rd1_e[3] !== 32'h0)        begin n_fail++; $display("FAIL e_bypass_e: got %h expected 0", rd1_e[3]); end
        tick();
        clear_inputs();
        DbgAdr = 5'd20; a1[0] = 5'd20;
        #2;
        n_cmp += 7;
        if (dbg_n !== 32'h0000BEEF) begin n_fail++; $display("FAIL e_dbg_n: got %h expected 0000beef", dbg_n); end
        if (dbg_e !== 32'h0)        begin n_fail++; $display("FAIL e_dbg_e: got %h expected 0", dbg_e); end
        if (rd1_e[0] !== 32'h0)     begin n_fail++; $display("FAIL e_read_e: got %h expected 0", rd1_e[0]); end
        if (cf_n !== 1'b1)          begin n_fail++; $display("FAIL e_cf_n: got %b expected 1", cf_n); end
        if (cf_e !== 1'b0)          begin n_fail++; $display("FAIL e_cf_e: got %b expected 0", cf_e); end
        if (cnt_n !== 16'd2)        begin n_fail++; $display("FAIL e_cnt_n: got %h expected 2", cnt_n); end
        if (cnt_e !== 16'd1)        begin n_fail++; $display("FAIL e_cnt_e: got %h expected 1", cnt_e); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp, got;
        for (int it = 0; it < 400; it++) begin
            for (int l = 0; l < 4; l++) begin
                we3[l] = 1'($urandom_range(0, 1));
                a3[l] = rand_addr(); wd3[l] = $urandom;
                a1[l] = rand_addr(); a2[l] = rand_addr();
            end
            #2;
            for (int md = 0; md < 2; md++) begin
                for (int l = 0; l < 4; l++) begin
                    exp = m_read(a1[l], md); got = md ? rd1_e[l] : rd1_n[l];
                    n_cmp++;
                    if (got !== exp) begin n_fail++; $display("FAIL rand_rd1 cfg%0d lane%0d a=%0d: got %h expected %h", md, l, a1[l], got, exp); end
                    exp = m_read(a2[l], md); got = md ? rd2_e[l] : rd2_n[l];
                    n_cmp++;
                    if (got !== exp) begin n_fail++; $display("FAIL rand_rd2 cfg%0d lane%0d a=%0d: got %h expected %h", md, l, a2[l], got, exp); end
                end
            end
            tick();
            DbgAdr = 5'($urandom_range(0, 31));
            #2;
            for (int md = 0; md < 2; md++) begin
                got = md ? dbg_e : dbg_n;
                n_cmp++;
                if (got !== m_reg[md][DbgAdr]) begin n_fail++; $display("FAIL rand_dbg cfg%0d a=%0d: got %h expected %h", md, DbgAdr, got, m_reg[md][DbgAdr]); end
                n_cmp++;
                if ((md ? cf_e : cf_n) !== m_cf[md]) begin n_fail++; $display("FAIL rand_cf cfg%0d: got %b expected %b", md, md ? cf_e : cf_n, m_cf[md]); end
                n_cmp++;
                if ((md ? cnt_e : cnt_n) !== m_cnt[md]) begin n_fail++; $display("FAIL rand_cnt cfg%0d: got %h expected %h", md, md ? cnt_e : cnt_n, m_cnt[md]); end
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        we3 = 4'b1011;
        a3[0] = 5'd5; wd3[0] = 32'h55;
        a3[1] = 5'd7; wd3[1] = 32'h71;
        a3[3] = 5'd7; wd3[3] = 32'h77;
        tick();
        clear_inputs();
        DbgAdr = 5'd7;
        #1;
        n_cmp += 2;
        if (dbg_n !== 32'h77) begin n_fail++; $display("FAIL arst_pre_dbg_n: got %h expected 77", dbg_n); end
        if (cnt_n !== m_cnt[0]) begin n_fail++; $display("FAIL arst_pre_cnt_n: got %h expected %h", cnt_n, m_cnt[0]); end
        we3 = 4'b0101;
        a3[0] = 5'd5; wd3[0] = 32'hA5A5;
        a3[2] = 5'd7; wd3[2] = 32'hB7;
        a1[0] = 5'd5;
        #2;
        reset = 1'b0;
        m_zero();
        #1;
        n_cmp += 6;
        if (dbg_n !== 32'h0)     begin n_fail++; $display("FAIL arst_x7_n: got %h expected 0", dbg_n); end
        if (dbg_e !== 32'h0)     begin n_fail++; $display("FAIL arst_x7_e: got %h expected 0", dbg_e); end
        if (cnt_n !== 16'h0)     begin n_fail++; $display("FAIL arst_cnt_n: got %h expected 0", cnt_n); end
        if (cf_n !== 1'b0)       begin n_fail++; $display("FAIL arst_cf_n: got %b expected 0", cf_n); end
        if (rd1_n[0] !== 32'hA5A5) begin n_fail++; $display("FAIL arst_bypass_n: got %h expected a5a5", rd1_n[0]); end
        if (cnt_e !== 16'h0)     begin n_fail++; $display("FAIL arst_cnt_e: got %h expected 0", cnt_e); end
        DbgAdr = 5'd5;
        #1;
        n_cmp++;
        if (dbg_n !== 32'h0) begin n_fail++; $display("FAIL arst_x5_n: got %h expected 0", dbg_n); end
        tick();
        n_cmp++;
        if (dbg_n !== 32'h0) begin n_fail++; $display("FAIL arst_edge_x5_n: got %h expected 0", dbg_n); end
        DbgAdr = 5'd7;
        #1;
        n_cmp++;
        if (dbg_n !== 32'h0) begin n_fail++; $display("FAIL arst_edge_x7_n: got %h expected 0", dbg_n); end
        clear_inputs();
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        reset = 1'b0;
        #1;
        m_zero();
        reset = 1'b1;
        we3 = 4'b0011;
        a3[0] = 5'd1; a3[1] = 5'd1;
        wd3[0] = 32'h11; wd3[1] = 32'h22;
        for (int i = 0; i < 65534; i++) tick();
        n_cmp += 2;
        if (cnt_n !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe_n: got %h expected fffe", cnt_n); end
        if (cnt_e !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe_e: got %h expected fffe", cnt_e); end
        tick();
        n_cmp += 2;
        if (cnt_n !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff_n: got %h expected ffff", cnt_n); end
        if (cf_n !== 1'b1)      begin n_fail++; $display("FAIL sat_cf_n: got %b expected 1", cf_n); end
        tick();
        n_cmp += 2;
        if (cnt_n !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold_n: got %h expected ffff", cnt_n); end
        if (cnt_e !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold_e: got %h expected ffff", cnt_e); end
        clear_inputs();
        tick();
        n_cmp += 2;
        if (cnt_n !== 16'hFFFF) begin n_fail++; $display("FAIL sat_idle_n: got %h expected ffff", cnt_n); end
        if (cf_n !== 1'b0)      begin n_fail++; $display("FAIL sat_idle_cf_n: got %b expected 0", cf_n); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_collision();
        test_x0();
        test_emode();
        test_random();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
